// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped instruction cache returning whole 64-byte lines
// Misses are refilled from the 64-bit bus as eight read beats.
module icache_responder #(
  parameter int SETS  = 64,
  parameter int BEATS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ic_enable,
  input  logic [63:0]  iaddr,
  output logic [511:0] idata,
  output logic         ic_done,
  output logic         bus_reqcyc,
  output logic [63:0]  bus_req,
  output logic [11:0]  bus_reqtag,
  input  logic         bus_reqack,
  input  logic         bus_respcyc,
  input  logic [63:0]  bus_resp,
  output logic         bus_respack
);

  localparam int L  = $clog2(SETS);
  localparam int TW = 64 - 6 - L;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, MISS_FILL, RESPOND} state_t;

  state_t state, state_next;

  logic [TW-1:0]  tag_mem  [SETS];
  logic [511:0]   data_mem [SETS];
  logic [SETS-1:0] valid;

  logic [63:0]  req_addr;
  logic [TW-1:0] rd_tag;
  logic [511:0] rd_data;
  logic         rd_valid;
  logic [2:0]   beat_cnt;
  logic [447:0] fill_buf;

  logic [L-1:0]  in_idx, req_idx;
  logic [TW-1:0] req_tag;
  logic          hit, last_beat;
  logic [511:0]  fill_line;
  logic          unused_ok;

  assign in_idx     = iaddr[6 +: L];
  assign req_idx    = req_addr[6 +: L];
  assign req_tag    = req_addr[63 -: TW];
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign last_beat  = (state == MISS_FILL) && bus_respcyc && (beat_cnt == 3'(BEATS - 1));
  // The final beat completes the line directly from the bus, so only seven beats are buffered.
  assign fill_line  = {bus_resp, fill_buf};
  assign bus_reqtag = 12'h900;
  assign bus_respack = bus_respcyc;
  assign unused_ok  = &{1'b0, iaddr[5:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (ic_enable) state_next = LOOKUP;
      LOOKUP:    state_next = hit ? RESPOND : MISS_REQ;
      MISS_REQ:  if (bus_reqack) state_next = MISS_FILL;
      MISS_FILL: if (last_beat) state_next = RESPOND;
      RESPOND:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= '0;
      ic_done    <= 1'b0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      idata      <= '0;
      beat_cnt   <= '0;
    end else begin
      ic_done <= (state_next == RESPOND);
      case (state)
        IDLE: begin
          if (ic_enable) begin
            req_addr <= {iaddr[63:6], 6'b0};
            rd_tag   <= tag_mem[in_idx];
            rd_data  <= data_mem[in_idx];
            rd_valid <= valid[in_idx];
          end
        end
        LOOKUP: begin
          if (hit) begin
            idata <= rd_data;
          end else begin
            bus_reqcyc <= 1'b1;
            bus_req    <= req_addr;
          end
        end
        MISS_REQ: begin
          if (bus_reqack) begin
            bus_reqcyc <= 1'b0;
            beat_cnt   <= '0;
          end
        end
        MISS_FILL: begin
          if (bus_respcyc) begin
            if (last_beat) begin
              valid[req_idx] <= 1'b1;
              idata          <= fill_line;
            end else begin
              fill_buf[{beat_cnt, 6'b0} +: 64] <= bus_resp;
            end
            beat_cnt <= beat_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && last_beat) begin
      tag_mem[req_idx]  <= req_tag;
      data_mem[req_idx] <= fill_line;
    end
  end

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - scoreboard bench for icache_responder
module tb_icache_responder;

  localparam logic [63:0] STEP = 64'h0808080808080808;
  localparam logic [63:0] B1   = 64'h0706050403020100;
  localparam logic [63:0] B2   = 64'hA0A1A2A3A4A5A6A7;
  localparam logic [63:0] B3   = 64'h3000000000000011;
  localparam logic [63:0] B4   = 64'h4040404000000000;
  localparam logic [63:0] B5   = 64'h5500550055005500;

  logic         clk = 1'b0;
  logic         reset, ic_enable;
  logic [63:0]  iaddr;
  logic [511:0] idata;
  logic         ic_done, bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0]  bus_req, bus_resp;
  logic [11:0]  bus_reqtag;

  int checks = 0;
  int errors = 0;
  logic [511:0] exp_q[$];
  logic [63:0]  req_q[$];
  logic [511:0] l1;

  icache_responder dut (
    .clk(clk), .reset(reset), .ic_enable(ic_enable), .iaddr(iaddr),
    .idata(idata), .ic_done(ic_done),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [511:0] mk_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k) * STEP;
    return l;
  endfunction

  // Monitor: checks every bus request and every ic_done against the scoreboard queues.
  initial begin
    logic prev_reqcyc;
    logic [63:0] held;
    prev_reqcyc = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      #1;
      chk("respack", bus_respack, bus_respcyc);
      if (bus_reqcyc && !prev_reqcyc) begin
        if (req_q.size() == 0) fail("unexpected_bus_request");
        else begin
          held = req_q.pop_front();
          chk("bus_req", bus_req, held);
          chk("bus_reqtag", bus_reqtag, 12'h900);
        end
      end else if (bus_reqcyc) begin
        chk("bus_req_stable", bus_req, held);
      end
      if (ic_done) begin
        chk("done_with_reqcyc", bus_reqcyc, 0);
        if (exp_q.size() == 0) fail("unexpected_ic_done");
        else chk("idata", idata, exp_q.pop_front());
      end
      prev_reqcyc = bus_reqcyc;
    end
  end

  task automatic request(input logic [63:0] a, input logic [511:0] line, input bit miss);
    exp_q.push_back(line);
    if (miss) req_q.push_back({a[63:6], 6'b0});
    @(negedge clk);
    ic_enable = 1'b1;
    iaddr     = a;
    @(negedge clk);
    ic_enable = 1'b0;
  endtask

  task automatic serve(input logic [63:0] base, input int ack_delay, input int gap_at,
                       input int gap_len, input int nbeats, input int poke_at);
    int t = 0;
    while (!bus_reqcyc && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus_reqcyc) begin
      fail("reqcyc_timeout");
      return;
    end
    repeat (ack_delay) @(negedge clk);
    bus_reqack = 1'b1;
    @(negedge clk);
    bus_reqack = 1'b0;
    for (int k = 0; k < nbeats; k++) begin
      if (k == gap_at) begin
        bus_respcyc = 1'b0;
        repeat (gap_len) @(negedge clk);
      end
      bus_respcyc = 1'b1;
      bus_resp    = base + 64'(k) * STEP;
      if (k == poke_at) begin
        ic_enable = 1'b1;
        iaddr     = 64'h2000_0000;
      end
      @(negedge clk);
      ic_enable = 1'b0;
    end
    bus_respcyc = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) fail("ic_done_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 64; i++) l1[i*8 +: 8] = 8'(i);
    reset = 1'b1; ic_enable = 1'b0; iaddr = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
    repeat (3) @(negedge clk);
    chk("reset_ic_done", ic_done, 0);
    chk("reset_reqcyc", bus_reqcyc, 0);
    chk("reset_bus_req", bus_req, 0);
    chk("reset_idata", idata, 0);
    reset = 1'b0;

    // cold miss
    request(64'h1000_0025, l1, 1'b1);
    serve(B1, 0, -1, 0, 8, -1);
    wait_idle();

    // hit with latency
    exp_q.push_back(l1);
    @(negedge clk);
    ic_enable = 1'b1;
    iaddr     = 64'h1000_0030;
    @(negedge clk);
    ic_enable = 1'b0;
    lat = 1;
    while (!ic_done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("hit_latency", lat, 2);
    wait_idle();

    // conflict on index 0
    request(64'h1000_1000, mk_line(B2), 1'b1);
    serve(B2, 0, -1, 0, 8, -1);
    wait_idle();
    request(64'h1000_0000, l1, 1'b1);
    serve(B1, 0, -1, 0, 8, -1);
    wait_idle();
    request(64'h1000_0008, l1, 1'b0);
    wait_idle();

    // delayed ack and gap between beats 2 and 3
    request(64'h4000_0040, mk_line(B4), 1'b1);
    serve(B4, 5, 3, 3, 8, -1);
    wait_idle();

    // ic_enable during fill is ignored
    request(64'h5000_0080, mk_line(B5), 1'b1);
    serve(B5, 0, -1, 0, 8, 4);
    wait_idle();
    repeat (10) @(negedge clk);

    // reset mid-fill, stray beats, then refetch
    request(64'h3000_0000, mk_line(B3), 1'b1);
    serve(B3, 0, -1, 0, 4, -1);
    exp_q.delete();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_reqcyc", bus_reqcyc, 0);
    for (int k = 0; k < 3; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'hDEAD_0000_0000_0000 + 64'(k);
      @(negedge clk);
    end
    bus_respcyc = 1'b0;
    repeat (5) @(negedge clk);
    request(64'h3000_0000, mk_line(B3), 1'b1);
    serve(B3, 0, -1, 0, 8, -1);
    wait_idle();

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("req_q_drained", req_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder: the cache side of the fetch interface (ic_enable/iaddr → idata/ic_done).
- Returns one full 64-byte line per request.
- Direct-mapped array; misses are filled from the 64-bit memory bus as 8 read beats.
- Sits between the instruction-fetch unit and the system bus arbiter.

Parameters:
SETS, 64, number of direct-mapped lines (power of two, ≥2); index = iaddr[6 +: log2(SETS)]
BEATS, 8, bus beats per line (64 B / 8 B); fixed, not independently changeable

Ports:
clk  in  1  clock; all state changes on posedge
reset  in  1  synchronous, active-high reset
ic_enable  in  1  fetch request strobe (one-cycle pulse from fetch)
iaddr  in  64  request address; bits [5:0] ignored
idata  out  512  line data; byte i of line = idata[i*8 +: 8]
ic_done  out  1  one-cycle pulse: idata valid for the accepted request
bus_reqcyc  out  1  bus read request valid
bus_req  out  64  line address, bits [5:0] = 0
bus_reqtag  out  12  {READ=1'b1, MEMORY=3'b001, 8'h00} = 12'h900
bus_reqack  in  1  bus accepted request
bus_respcyc  in  1  response beat valid
bus_resp  in  64  response beat data
bus_respack  out  1  equals bus_respcyc (always accepting)

Behaviour:
- Reset (synchronous): all valid bits cleared; state IDLE; ic_done=0, bus_reqcyc=0, bus_req=0, idata=0, beat counter=0. Tag/data arrays are not cleared.
- Reset mid-operation: any lookup or fill is abandoned, with no ic_done and no array write. Beats arriving afterwards in IDLE are acked and discarded.
- Address split: offset [5:0], index [6 +: L] with L = log2(SETS), tag [63 : 6+L].
- States: IDLE, LOOKUP, MISS_REQ, MISS_FILL, RESPOND.
- IDLE:
  - ic_enable=1 latches iaddr & ~63 into req_addr and moves to LOOKUP.
  - ic_enable in any other state is ignored; no queueing.
- LOOKUP (array read registered):
  - Hit (valid & tag match): load idata from the array, go to RESPOND.
  - Miss: go to MISS_REQ.
- Hit latency: ic_enable sampled at edge N → ic_done=1 during cycle N+2.
- MISS_REQ:
  - bus_reqcyc=1, bus_req=req_addr, bus_reqtag=12'h900, all held stable until bus_reqack=1 is sampled.
  - Then bus_reqcyc drops next cycle; beat counter=0; go to MISS_FILL.
  - reqack in the same cycle reqcyc first rises is legal.
- MISS_FILL:
  - Each bus_respcyc cycle writes bus_resp into fill_buf[k*64 +: 64] (k = beat counter, 3 bits) and increments k.
  - Cycles without respcyc hold state; gaps between beats are allowed.
  - On beat 7: write tag, data and valid for the index; idata = completed line; go to RESPOND.
- RESPOND: ic_done=1 for exactly one cycle, then IDLE. A request may be accepted the next cycle.
- idata holds its value until the next ic_done; it changes only on the cycle before ic_done.
- Conflict: a miss to an index with a valid, different tag overwrites the line.
- Same-line request after a fill is a hit.
- bus_respack = bus_respcyc combinationally in all states.
- ic_done is never asserted in the same cycle as bus_reqcyc.

Test Plan:
- Cold miss: reset, ic_enable with iaddr=0x1000_0025 → bus_req=0x1000_0000, reqtag=0x900; 8 beats 0x0706050403020100 + k*0x0808080808080808 → ic_done one cycle, idata byte i = i (i=0..63).
- Hit: repeat iaddr=0x1000_0030 → no bus_reqcyc; ic_done exactly 2 cycles after ic_enable; same idata.
- Conflict: SETS=64, fill 0x1000_0000, then request 0x1000_1000 (same index 0) → miss and bus read of 0x1000_1000; a subsequent 0x1000_0000 request misses again.
- Handshake stalls: bus_reqack delayed 5 cycles, idle gaps of 3 cycles between beats 2/3 → bus_req stable throughout, beats placed correctly, single ic_done.
- Busy ignore: ic_enable pulse with 0x2000_0000 during MISS_FILL → no second bus request, no extra ic_done.
- Reset mid-fill: reset after beat 4 of 0x3000_0000, then 3 stray beats → no ic_done; a later request to 0x3000_0000 misses and refetches.
